// File: rtl/gpio_capture_pkg.sv
// Shared constants for the GPIO capture block: register word addresses and
// interrupt source encodings.
package gpio_capture_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  localparam int EDGE_LEVEL   = 0;
  localparam int EDGE_RISING  = 1;
  localparam int EDGE_FALLING = 2;
  localparam int EDGE_ANY     = 3;

endpackage

// File: rtl/gpio_capture_sync.sv
// Pin synchronizer chain plus previous-value register; emits the synchronized
// pin vector and the per-bit edge strobe selected by EDGE_MODE.
module gpio_capture_sync
  import gpio_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_MODE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '{default: '0};
      prev  <= '0;
    end else begin
      stage[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign sync = stage[SYNC_STAGES-1];

  always_comb begin
    edges = '0;
    case (EDGE_MODE)
      EDGE_RISING:  edges = sync & ~prev;
      EDGE_FALLING: edges = ~sync & prev;
      EDGE_ANY:     edges = sync ^ prev;
      default:      edges = '0;
    endcase
  end

endmodule

// File: rtl/gpio_capture.sv
// Avalon-MM GPIO block with output/direction registers, sticky edge capture
// and a level interrupt.
module gpio_capture
  import gpio_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_MODE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_next;
  logic             wr;

  gpio_capture_sync #(
    .WIDTH      (WIDTH),
    .EDGE_MODE  (EDGE_MODE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .sync   (sync),
    .edges  (edges)
  );

  assign wr    = chipselect && !write_n;
  assign wdata = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= '0;
      dir_reg  <= '0;
      mask_reg <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:      out_reg  <= wdata;
        ADDR_DIRECTION: dir_reg  <= wdata;
        ADDR_IRQ_MASK:  mask_reg <= wdata;
        ADDR_OUTSET:    out_reg  <= out_reg | wdata;
        ADDR_OUTCLEAR:  out_reg  <= out_reg & ~wdata;
        default: ;
      endcase
    end
  end

  // Clear is applied before the OR so a coincident edge keeps the bit set.
  assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_reg <= '0;
    end else if (EDGE_MODE == EDGE_LEVEL) begin
      cap_reg <= '0;
    end else begin
      cap_reg <= (cap_reg & ~cap_clr) | edges;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:      rd_next[WIDTH-1:0] = sync;
      ADDR_DIRECTION: rd_next[WIDTH-1:0] = dir_reg;
      ADDR_IRQ_MASK:  rd_next[WIDTH-1:0] = mask_reg;
      ADDR_EDGE_CAP:  rd_next[WIDTH-1:0] = cap_reg;
      ADDR_OUTSET,
      ADDR_OUTCLEAR:  rd_next[WIDTH-1:0] = out_reg;
      default:        rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign out_port = out_reg;
  assign oe       = dir_reg;
  assign irq      = (EDGE_MODE == EDGE_LEVEL) ? |(sync & mask_reg)
                                              : |(cap_reg & mask_reg);

endmodule

// File: tb/tb_gpio_capture.sv
// Directed bench: one rising-edge instance and one level-mode instance share
// the bus wires but have separate chip selects and pins.
module tb_gpio_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        cs_r = 1'b0;
  logic        cs_l = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd_r, rd_l;
  logic [7:0]  in_r = '0, in_l = '0;
  logic [7:0]  out_r, out_l, oe_r, oe_l;
  logic        irq_r, irq_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_capture #(.WIDTH(8), .EDGE_MODE(1), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_r),
    .write_n(write_n), .writedata(writedata), .readdata(rd_r),
    .in_port(in_r), .out_port(out_r), .oe(oe_r), .irq(irq_r)
  );

  gpio_capture #(.WIDTH(8), .EDGE_MODE(0), .SYNC_STAGES(2)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_l),
    .write_n(write_n), .writedata(writedata), .readdata(rd_l),
    .in_port(in_l), .out_port(out_l), .oe(oe_l), .irq(irq_l)
  );

  typedef struct {
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic lvl, input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0;
    if (lvl) cs_l = 1'b1; else cs_r = 1'b1;
    @(negedge clk);
    cs_r = 1'b0; cs_l = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic lvl, input logic [2:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = lvl ? rd_l : rd_r;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;

  initial begin
    vecs[0] = '{3'd0, 32'h0000_00A5, 3'd4, 32'h0000_00A5, 8'hA5, 8'h00};
    vecs[1] = '{3'd4, 32'h0000_000A, 3'd5, 32'h0000_00AF, 8'hAF, 8'h00};
    vecs[2] = '{3'd5, 32'h0000_0081, 3'd4, 32'h0000_002E, 8'h2E, 8'h00};
    vecs[3] = '{3'd1, 32'h0000_00F0, 3'd1, 32'h0000_00F0, 8'h2E, 8'hF0};
    vecs[4] = '{3'd1, 32'hFFFF_FFFF, 3'd1, 32'h0000_00FF, 8'h2E, 8'hFF};
    vecs[5] = '{3'd1, 32'h0000_00F0, 3'd6, 32'h0000_0000, 8'h2E, 8'hF0};
    vecs[6] = '{3'd2, 32'h0000_00FF, 3'd7, 32'h0000_0000, 8'h2E, 8'hF0};
    vecs[7] = '{3'd2, 32'h0000_0041, 3'd2, 32'h0000_0041, 8'h2E, 8'hF0};

    // Reset state
    idle(2);
    chk("reset_rd_r",  rd_r,  0);
    chk("reset_out_r", out_r, 0);
    chk("reset_oe_r",  oe_r,  0);
    chk("reset_irq_r", irq_r, 0);
    chk("reset_irq_l", irq_l, 0);
    reset_n = 1'b1;
    idle(2);

    // Register read/write vectors on the rising instance
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, vecs[i].wa, vecs[i].wd);
      rd(1'b0, vecs[i].ra, v);
      chk($sformatf("vec%0d_rd", i), v, vecs[i].exp_rd);
      chk($sformatf("vec%0d_out", i), out_r, vecs[i].exp_out);
      chk($sformatf("vec%0d_oe", i), oe_r, vecs[i].exp_oe);
    end
    chk("masked_irq_idle", irq_r, 0);

    // DATA read returns pins, not the output register
    in_r = 8'h3C;
    idle(4);
    rd(1'b0, 3'd0, v);
    chk("data_reads_pins", v, 32'h3C);
    chk("out_unchanged", out_r, 8'h2E);
    rd(1'b0, 3'd3, v);
    chk("cap_after_rise", v, 32'h3C);
    chk("irq_masked_off", irq_r, 0);
    wr(1'b0, 3'd3, 32'hFF);
    rd(1'b0, 3'd3, v);
    chk("cap_w1c_all", v, 0);

    // Rising edge latency: capture and irq exactly three edges after change
    wr(1'b0, 3'd2, 32'h01);
    in_r = 8'h3D;
    @(negedge clk); chk("lat_edge1_irq", irq_r, 0);
    @(negedge clk); chk("lat_edge2_irq", irq_r, 0);
    @(negedge clk); chk("lat_edge3_irq", irq_r, 1);
    rd(1'b0, 3'd3, v);
    chk("lat_cap", v, 32'h01);
    wr(1'b0, 3'd3, 32'h01);
    chk("irq_cleared", irq_r, 0);

    // Set wins over a coincident write-1-to-clear
    in_r = 8'h39;
    idle(4);
    rd(1'b0, 3'd3, v);
    chk("fall_ignored", v, 0);
    in_r = 8'h3D;
    idle(2);
    wr(1'b0, 3'd3, 32'h04);
    rd(1'b0, 3'd3, v);
    chk("set_wins", v, 32'h04);
    wr(1'b0, 3'd3, 32'h04);
    rd(1'b0, 3'd3, v);
    chk("clear_after_set", v, 0);
    wr(1'b0, 3'd3, 32'h00);
    chk("w0_no_irq", irq_r, 0);

    // Level mode
    wr(1'b1, 3'd2, 32'h80);
    rd(1'b1, 3'd3, v);
    chk("lvl_cap_zero", v, 0);
    in_l = 8'h80;
    @(negedge clk); chk("lvl_edge1_irq", irq_l, 0);
    @(negedge clk); chk("lvl_edge2_irq", irq_l, 1);
    wr(1'b1, 3'd3, 32'hFF);
    rd(1'b1, 3'd3, v);
    chk("lvl_cap_ignores_wr", v, 0);
    rd(1'b1, 3'd0, v);
    chk("lvl_data_pins", v, 32'h80);
    in_l = 8'h00;
    @(negedge clk); chk("lvl_drop1_irq", irq_l, 1);
    @(negedge clk); chk("lvl_drop2_irq", irq_l, 0);
    chk("lvl_out_untouched", out_l, 0);

    // Reset mid-operation with capture 0x0F and mask 0xFF
    in_r = 8'h30;
    idle(4);
    wr(1'b0, 3'd3, 32'hFF);
    wr(1'b0, 3'd2, 32'hFF);
    in_r = 8'h3F;
    idle(4);
    rd(1'b0, 3'd3, v);
    chk("pre_reset_cap", v, 32'h0F);
    chk("pre_reset_irq", irq_r, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_reset_irq", irq_r, 0);
    chk("mid_reset_out", out_r, 0);
    chk("mid_reset_oe", oe_r, 0);
    chk("mid_reset_rd", rd_r, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(1'b0, 3'd2, v);
    chk("post_reset_mask", v, 0);
    rd(1'b0, 3'd1, v);
    chk("post_reset_dir", v, 0);
    rd(1'b0, 3'd4, v);
    chk("post_reset_outreg", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_capture.md
GPIO_CAPTURE -- requirements
Module: gpio_capture

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO bits, legal range 1..32.
REQ-002 Parameter EDGE_MODE, default 1, interrupt source: 0 level-high, 1 rising, 2 falling, 3 any edge.
REQ-003 Parameter SYNC_STAGES, default 2, input synchronizer depth, legal range 2..4.
REQ-004 Port clk, input, 1, sole clock; all state on rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port address, input, 3, Avalon-MM word address.
REQ-007 Port chipselect, input, 1, slave select.
REQ-008 Port write_n, input, 1, active-low write strobe.
REQ-009 Port writedata, input, 32, write data.
REQ-010 Port readdata, output, 32, registered read data.
REQ-011 Port in_port, input, WIDTH, asynchronous pin inputs.
REQ-012 Port out_port, output, WIDTH, output data register value.
REQ-013 Port oe, output, WIDTH, per-bit output enable (1 = drive), equals direction register.
REQ-014 Port irq, output, 1, level interrupt request.

Function
REQ-015 Register map: 0 DATA, 1 DIRECTION, 2 IRQ_MASK, 3 EDGE_CAPTURE, 4 OUTSET, 5 OUTCLEAR; 6-7 reserved.
REQ-016 A write occurs on a clock edge with chipselect=1 and write_n=0; only writedata[WIDTH-1:0] used.
REQ-017 DATA write loads the output register; DATA read returns the synchronized pin value (final sync stage), regardless of direction.
REQ-018 OUTSET write ORs writedata into the output register; OUTCLEAR write clears bits set in writedata; reads of 4/5 return the output register.
REQ-019 DIRECTION and IRQ_MASK are read/write registers.
REQ-020 EDGE_CAPTURE write is write-1-to-clear per bit; writing 0 leaves bit unchanged.
REQ-021 readdata updates every clock edge from address (chipselect ignored), one-cycle read latency; bits [31:WIDTH] and reserved addresses read 0.
REQ-022 in_port passes through SYNC_STAGES flip-flops, then one previous-value register for edge detection.
REQ-023 Edge detected on bit i: rising = sync & ~prev, falling = ~sync & prev, any = sync ^ prev, per EDGE_MODE.
REQ-024 Detected edge sets EDGE_CAPTURE bit; a bit stays set until cleared by software.
REQ-025 Simultaneous edge detection and write-1-to-clear on the same bit: set wins.
REQ-026 In-port transition to EDGE_CAPTURE set: SYNC_STAGES+1 clock edges after the first sampling edge.
REQ-027 EDGE_MODE 1-3: irq = OR over bits of (EDGE_CAPTURE & IRQ_MASK); combinational from registers, no added latency.
REQ-028 EDGE_MODE 0: EDGE_CAPTURE holds 0 and ignores writes; irq = OR over bits of (sync & IRQ_MASK).
REQ-029 Pulses shorter than one clock period are not guaranteed to be captured.

Reset
REQ-030 reset_n low asynchronously clears readdata, output register, DIRECTION, IRQ_MASK, EDGE_CAPTURE, sync chain and prev register to 0.
REQ-031 Consequently out_port=0, oe=0, irq=0 during and immediately after reset.
REQ-032 First clock edges after reset release do not generate spurious edges from the zeroed prev register for inputs held low; inputs held high produce one rising edge, which is accepted behaviour.

Structure
REQ-033 Package gpio_capture_pkg holds register address constants and EDGE_MODE encodings.
REQ-034 Sub-module gpio_capture_sync implements the WIDTH-wide synchronizer chain and prev register, outputting sync and edge vectors.

Verification
REQ-035 Reset: assert reset_n mid-operation with IRQ_MASK=0xFF, capture=0x0F -> all registers, readdata, irq read 0 immediately.
REQ-036 Rising mode, WIDTH=8: mask=0x01, in_port 0x00->0x01 -> EDGE_CAPTURE=0x01 and irq=1 exactly 3 edges later; write 0x01 to addr 3 -> irq=0 next cycle.
REQ-037 Set-wins: rising edge on bit 2 coincides with write 0x04 to EDGE_CAPTURE -> bit 2 remains 1.
REQ-038 Outputs: write DATA=0xA5, OUTSET=0x0A, OUTCLEAR=0x81 -> out_port=0x2E; DIRECTION=0xF0 -> oe=0xF0; read addr 0 returns pins not 0x2E.
REQ-039 Level mode (EDGE_MODE=0): mask=0x80, in_port[7] high -> irq=1 after SYNC_STAGES edges, drops after in_port[7] low; EDGE_CAPTURE reads 0.
REQ-040 Reads: addr 6 and 7 return 0; WIDTH=8 write 0xFFFFFFFF to DIRECTION reads 0x000000FF one cycle after address presented.
